// File: rtl/gmii_tx_framer_pkg.sv
// Shared types and constants for the GMII transmit framer.
package gmii_tx_framer_pkg;

    typedef enum logic [2:0] {
        IDLE, PRE, SFD, DATA, PAD, FCS, IFG, ABORT
    } state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/gmii_tx_framer_crc32_d8.sv
// Byte-wide reflected CRC-32 next-state function (LSB of data first).
module crc32_d8
    import gmii_tx_framer_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    localparam logic [31:0] POLY_R = bitrev32(CRC_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload with zero padding,
// CRC-32 FCS, inter-frame gap and underrun abort.
module gmii_tx_framer
    import gmii_tx_framer_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_PAYLOAD  = 60,
    parameter int unsigned PAD_EN       = 1,
    parameter int unsigned IFG_BYTES    = 12
) (
    input  logic       tx_clk_125,
    input  logic       rst,
    input  logic       tx_clock_enable_sink,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] tx_d,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] MIN_P    = 16'(MIN_PAYLOAD);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  tx_d_q, tx_d_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        done_q, done_d;
    logic        urun_q, urun_d;

    logic [15:0] cnt_inc;
    logic        pad_need;
    logic [7:0]  crc_byte;
    logic [31:0] crc_next;

    // The state names the byte that goes out at the next enabled edge.
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign pad_need = (PAD_EN != 0) && (cnt_inc < MIN_P);
    assign crc_byte = (state_q == PAD) ? 8'h00 : s_data;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (crc_byte),
        .crc_o  (crc_next)
    );

    always_ff @(posedge tx_clk_125) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            crc_q   <= CRC_INIT;
            tx_d_q  <= '0;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
            done_q  <= 1'b0;
            urun_q  <= 1'b0;
        end else if (tx_clock_enable_sink) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            tx_d_q  <= tx_d_d;
            tx_en_q <= tx_en_d;
            tx_er_q <= tx_er_d;
            done_q  <= done_d;
            urun_q  <= urun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (s_valid) state_d = (PREAMBLE_LEN > 1) ? PRE : SFD;
            PRE:   if (cnt_q == PRE_LAST) state_d = SFD;
            SFD:   state_d = DATA;
            DATA: begin
                if (!s_valid)    state_d = ABORT;
                else if (s_last) state_d = pad_need ? PAD : FCS;
            end
            PAD:   if (cnt_inc >= MIN_P) state_d = FCS;
            FCS:   if (cnt_q == 16'd3) state_d = IFG;
            IFG:   if (cnt_q >= IFG_LAST) state_d = IDLE;
            ABORT: state_d = (IFG_BYTES > 1) ? IFG : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d_d  = 8'h00;
        tx_en_d = 1'b0;
        tx_er_d = 1'b0;
        done_d  = 1'b0;
        urun_d  = 1'b0;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        case (state_q)
            IDLE: begin
                crc_d = CRC_INIT;
                cnt_d = 16'd0;
                if (s_valid) begin
                    tx_d_d  = PREAMBLE_BYTE;
                    tx_en_d = 1'b1;
                    cnt_d   = 16'd1;
                end
            end
            PRE: begin
                tx_d_d  = PREAMBLE_BYTE;
                tx_en_d = 1'b1;
                cnt_d   = cnt_inc;
            end
            SFD: begin
                tx_d_d  = SFD_BYTE;
                tx_en_d = 1'b1;
                cnt_d   = 16'd0;
            end
            DATA: begin
                tx_en_d = 1'b1;
                if (s_valid) begin
                    tx_d_d = s_data;
                    crc_d  = crc_next;
                    cnt_d  = (s_last && !pad_need) ? 16'd0 : cnt_inc;
                end else begin
                    tx_er_d = 1'b1;
                    urun_d  = 1'b1;
                    cnt_d   = 16'd0;
                end
            end
            PAD: begin
                tx_en_d = 1'b1;
                crc_d   = crc_next;
                cnt_d   = (cnt_inc >= MIN_P) ? 16'd0 : cnt_inc;
            end
            FCS: begin
                tx_d_d  = ~crc_q[7:0];
                tx_en_d = 1'b1;
                crc_d   = {8'h00, crc_q[31:8]};
                cnt_d   = cnt_inc;
                if (cnt_q == 16'd3) begin
                    done_d = 1'b1;
                    cnt_d  = 16'd0;
                end
            end
            IFG:   cnt_d = cnt_inc;
            // The abort byte-time's successor is already the first gap byte.
            ABORT: cnt_d = 16'd1;
            default: cnt_d = 16'd0;
        endcase
    end

    assign s_ready    = (state_q == DATA) & tx_clock_enable_sink;
    assign busy       = (state_q != IDLE);
    assign tx_d       = tx_d_q;
    assign tx_en      = tx_en_q;
    assign tx_er      = tx_er_q;
    assign frame_done = done_q;
    assign underrun   = urun_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Randomised self-checking bench for gmii_tx_framer against a
// frame-level reference model (byte stream, FCS, gap lengths).
module tb_gmii_tx_framer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic [7:0] sd   [2];
    logic       sv   [2];
    logic       sl   [2];
    logic       sr   [2];
    logic [7:0] txd  [2];
    logic       txen [2];
    logic       txer [2];
    logic       bsy  [2];
    logic       fd   [2];
    logic       ur   [2];

    int n_chk  = 0;
    int n_fail = 0;
    int div = 0, ph = 0, act = 0;

    logic [8:0] cap[$];
    logic [8:0] exq[$];
    logic [8:0] drvq[$];
    int         gaps[$];
    int         idle_n, ifg_len, n_fd, n_ur, en_clks, viol;
    bit         seen, post;
    logic [7:0] pd;
    logic       pe, pr;

    gmii_tx_framer #(.PAD_EN(0)) u_dut0 (
        .tx_clk_125(clk), .rst(rst), .tx_clock_enable_sink(en),
        .s_data(sd[0]), .s_valid(sv[0]), .s_last(sl[0]), .s_ready(sr[0]),
        .tx_d(txd[0]), .tx_en(txen[0]), .tx_er(txer[0]), .busy(bsy[0]),
        .frame_done(fd[0]), .underrun(ur[0])
    );

    gmii_tx_framer #(.PAD_EN(1)) u_dut1 (
        .tx_clk_125(clk), .rst(rst), .tx_clock_enable_sink(en),
        .s_data(sd[1]), .s_valid(sv[1]), .s_last(sl[1]), .s_ready(sr[1]),
        .tx_d(txd[1]), .tx_en(txen[1]), .tx_er(txer[1]), .busy(bsy[1]),
        .frame_done(fd[1]), .underrun(ur[1])
    );

    initial forever #4 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (div == 0)      en = 1'b0;
        else if (div == 1) en = 1'b1;
        else begin
            en = (ph == 0);
            ph = (ph + 1) % div;
        end
    end

    // Output monitor for the DUT currently under test.
    initial forever begin
        logic ene;
        @(posedge clk);
        ene = en;
        #1;
        if (txen[act]) en_clks++;
        if (!ene) begin
            if (txd[act] != pd || txen[act] != pe || txer[act] != pr) viol++;
        end else begin
            if (txen[act]) begin
                cap.push_back({txer[act], txd[act]});
                if (seen && idle_n > 0) gaps.push_back(idle_n);
                idle_n = 0;
                seen = 1;
                post = 1;
            end else begin
                idle_n++;
                if (post && !bsy[act]) begin
                    ifg_len = idle_n;
                    post = 0;
                end
            end
            if (fd[act]) n_fd++;
            if (ur[act]) n_ur++;
        end
        pd = txd[act];
        pe = txen[act];
        pr = txer[act];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic clear_mon(input int k);
        act = k;
        cap.delete();
        gaps.delete();
        exq.delete();
        drvq.delete();
        idle_n = 0; ifg_len = -1; n_fd = 0; n_ur = 0;
        en_clks = 0; viol = 0; seen = 0; post = 0;
    endtask

    // Model: preamble, SFD, payload, pad to 60 when enabled, FCS LSB first.
    task automatic add_frame(input logic [7:0] p[$], input bit pad);
        logic [7:0]  body[$];
        logic [31:0] crc;
        body = p;
        if (pad) while (body.size() < 60) body.push_back(8'h00);
        crc = fcs_of(body);
        for (int i = 0; i < 7; i++) exq.push_back(9'h055);
        exq.push_back(9'h0D5);
        foreach (body[i]) exq.push_back({1'b0, body[i]});
        for (int i = 0; i < 4; i++) exq.push_back({1'b0, crc[8*i +: 8]});
        foreach (p[i]) drvq.push_back({(i == p.size() - 1), p[i]});
    endtask

    task automatic drive(input int k, input logic [8:0] q[$]);
        int i = 0;
        int guard = 0;
        while (i < q.size()) begin
            @(negedge clk);
            sv[k] = 1'b1;
            sd[k] = q[i][7:0];
            sl[k] = q[i][8];
            #1;
            if (sr[k]) i++;
            guard++;
            if (guard > 20000) begin
                chk("drv_timeout", guard, 0);
                break;
            end
        end
        @(negedge clk);
        sv[k] = 1'b0;
        sl[k] = 1'b0;
        sd[k] = 8'h00;
    endtask

    task automatic wait_idle(input int k);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (bsy[k] && guard < 20000);
        if (guard >= 20000) chk("idle_timeout", guard, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int nfd, input int nur);
        chk($sformatf("%s_len", tag), cap.size(), exq.size());
        for (int i = 0; i < cap.size() && i < exq.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), {23'h0, cap[i]}, {23'h0, exq[i]});
        chk($sformatf("%s_done", tag), n_fd, nfd);
        chk($sformatf("%s_urun", tag), n_ur, nur);
        chk($sformatf("%s_ifg", tag), ifg_len, 12);
    endtask

    task automatic run_frame(input string tag, input int k,
                             input logic [7:0] p[$], input int d);
        @(negedge clk);
        div = d;
        clear_mon(k);
        add_frame(p, (k == 1));
        drive(k, drvq);
        wait_idle(k);
        check_frame(tag, 1, 0);
    endtask

    logic [7:0] p123[$];
    logic [7:0] pl[$];
    logic [7:0] p2[$];
    int         guard;
    int         dsel[4] = '{1, 2, 3, 7};

    initial begin
        for (int k = 0; k < 2; k++) begin
            sd[k] = 8'h00; sv[k] = 1'b0; sl[k] = 1'b0;
        end
        clear_mon(0);
        for (int i = 0; i < 9; i++) p123.push_back(8'(8'h31 + i));

        // Reset with the byte enable held low
        rst = 1'b1;
        div = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_txen%0d", k), txen[k], 0);
            chk($sformatf("rst_txd%0d", k), txd[k], 0);
            chk($sformatf("rst_txer%0d", k), txer[k], 0);
            chk($sformatf("rst_busy%0d", k), bsy[k], 0);
            chk($sformatf("rst_done%0d", k), fd[k], 0);
            chk($sformatf("rst_urun%0d", k), ur[k], 0);
        end
        rst = 1'b0;
        div = 1;
        repeat (2) @(negedge clk);

        // Test 1: "123456789" without padding
        run_frame("t1", 0, p123, 1);
        chk("t1_txen_clks", en_clks, 21);
        if (cap.size() >= 21) begin
            chk("t1_fcs0", cap[17], 9'h026);
            chk("t1_fcs1", cap[18], 9'h039);
            chk("t1_fcs2", cap[19], 9'h0F4);
            chk("t1_fcs3", cap[20], 9'h0CB);
        end else chk("t1_short", cap.size(), 21);

        // Test 2: single byte padded to minimum payload
        pl.delete();
        pl.push_back(8'hAB);
        run_frame("t2", 1, pl, 1);
        chk("t2_txen_clks", en_clks, 72);

        // Test 3: 1-in-10 byte enable
        run_frame("t3", 0, p123, 10);
        chk("t3_txen_clks", en_clks, 210);
        chk("t3_hold", viol, 0);

        // Test 4: source stalls after five payload bytes
        @(negedge clk);
        div = 1;
        clear_mon(1);
        for (int i = 0; i < 7; i++) exq.push_back(9'h055);
        exq.push_back(9'h0D5);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            drvq.push_back({1'b0, b});
            exq.push_back({1'b0, b});
        end
        exq.push_back(9'h100);
        drive(1, drvq);
        wait_idle(1);
        check_frame("t4", 0, 1);

        // Test 5: reset while the second FCS byte is on the wire
        @(negedge clk);
        clear_mon(0);
        add_frame(p123, 0);
        drive(0, drvq);
        guard = 0;
        while (cap.size() < 19 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("t5_reach_fcs", cap.size(), 19);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_txen", txen[0], 0);
        chk("t5_busy", bsy[0], 0);
        rst = 1'b0;
        run_frame("t5_restart", 0, p123, 1);

        // Test 6: back-to-back frames, s_valid held high
        @(negedge clk);
        clear_mon(0);
        p2.delete();
        for (int i = 0; i < 20; i++) p2.push_back(8'($urandom));
        add_frame(p123, 0);
        add_frame(p2, 0);
        drive(0, drvq);
        wait_idle(0);
        check_frame("t6", 2, 0);
        chk("t6_ngaps", gaps.size(), 1);
        if (gaps.size() > 0) chk("t6_gap", gaps[0], 12);

        // Randomised frames on both variants and enable rates
        for (int r = 0; r < 8; r++) begin
            int k;
            int len;
            k   = $urandom_range(0, 1);
            len = $urandom_range(1, 75);
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            run_frame($sformatf("rnd%0d", r), k, pl, dsel[$urandom_range(0, 3)]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
